light_slew_mux: RTL and testbench
=================================

LIGHT_SLEW_MUX -- requirements
Module: light_slew_mux

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, giving the number of selectable colour sources (legal range 2..16).
REQ-002 The block SHALL have parameter NUM_CH, default 3, giving the number of colour channels per source (R,G,B order, channel 0 in the MS bits).
REQ-003 The block SHALL have parameter CH_W, default 8, giving the width of each channel in bits.
REQ-004 The block SHALL have parameter STEP, default 16, giving the maximum per-cycle change of any channel (legal range 1..2^CH_W).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port src, input, NUM_SRC*NUM_CH*CH_W bits: sources packed flat, with source 0 in the LS word.
REQ-008 The block SHALL have port sel, input, clog2(NUM_SRC) bits: source select index.
REQ-009 The block SHALL have port enable, input, 1 bit: when high, the output slews toward the target; when low, the output freezes.
REQ-010 The block SHALL have port light, output, NUM_CH*CH_W bits: the registered output colour.
REQ-011 The block SHALL have port busy, output, 1 bit: combinational, high when light differs from the current target in any channel.
REQ-012 The block SHALL have port settled, output, 1 bit: a registered one-cycle pulse that fires when light reaches the target.

Function
REQ-013 The block SHALL take the target as src word sel when sel < NUM_SRC, and as the previously latched target otherwise.
REQ-014 The block SHALL register the latched target, updating it on every rising edge where sel < NUM_SRC, regardless of enable.
REQ-015 On each rising edge with enable=1, each channel SHALL move toward the target channel by min(STEP, |target-light|), computed unsigned at CH_W+1 bits without wrap-around.
REQ-016 Channels SHALL slew independently: a channel that has already matched its target SHALL hold while the other channels continue to move.
REQ-017 On edges with enable=0, light SHALL hold its value, settled SHALL be 0, and busy SHALL still reflect the current comparison.
REQ-018 If the target changes mid-slew, the slew SHALL continue from the current light value toward the new target on the next enabled edge, with no restart or jump.
REQ-019 With STEP >= 2^CH_W-1, light SHALL equal the target one enabled edge after any change.
REQ-020 settled SHALL be 1 for exactly the cycle following an enabled edge where light != target before the edge and the updated light == target.
REQ-021 settled SHALL NOT assert when light was already equal to the target.
REQ-022 The block SHALL implement a two-state FSM, IDLE (busy=0) and SLEW (busy=1).
REQ-023 The FSM SHALL move from IDLE to SLEW in the same cycle the target differs from light, and from SLEW to IDLE on the enabled edge that completes convergence.
REQ-024 sel changing on the same edge as convergence SHALL make the new target govern; settled SHALL fire only if the updated light equals the target in force after that edge.

Reset
REQ-025 While rst_n=0, light SHALL be all zeros, settled SHALL be 0, the latched target SHALL be all zeros, and the FSM SHALL be in IDLE, all taking effect immediately without waiting for a clock edge.
REQ-026 Reset asserted mid-slew SHALL abandon the slew, and after release the block SHALL resume from zero toward src[sel].
REQ-027 The first rising edge after rst_n rises SHALL be a normal operating edge.

Verification
REQ-028 The bench SHALL cover this scenario (defaults; src1=0xFF8010, enable=1, sel 0->1, src0=0): R SHALL step 0x10 per edge reaching 0xFF at edge 16, G SHALL reach 0x80 at edge 8, B SHALL reach 0x10 at edge 1, and settled SHALL pulse once after edge 16.
REQ-029 The bench SHALL cover this scenario: at light=0x808080 with sel switched to src2=0x7F8081 -> R SHALL go to 0x7F and B to 0x81 in one edge, G SHALL hold, and settled SHALL pulse once.
REQ-030 The bench SHALL cover this scenario: mid-slew of 0x000000->0xFFFFFF, enable held low for 5 cycles -> light SHALL freeze, busy SHALL stay 1, and the slew SHALL resume unchanged afterwards.
REQ-031 The bench SHALL cover this scenario: at light=0x404040 mid-slew upward, sel changed to source 0=0x000000 -> the next edges SHALL give 0x303030, 0x202020, ..., then settled SHALL pulse.
REQ-032 The bench SHALL cover this scenario: with NUM_SRC=3, sel=3 applied -> the target SHALL hold at the last legal source and light SHALL be unaffected.
REQ-033 The bench SHALL cover this scenario: rst_n pulsed low asynchronously mid-slew -> light SHALL read 0 before the next edge and the slew SHALL restart from 0.

Source files
------------

// File: rtl/light_slew_mux.sv
// Colour source multiplexer with a per-channel slew-rate limit on the registered output.
// busy flags any mismatch between light and target; settled pulses once when the slew completes.
module light_slew_mux #(
    parameter int NUM_SRC = 4,
    parameter int NUM_CH  = 3,
    parameter int CH_W    = 8,
    parameter int STEP    = 16,
    localparam int SEL_W  = $clog2(NUM_SRC),
    localparam int W      = NUM_CH * CH_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC*W-1:0] src,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 enable,
    output logic [W-1:0]         light,
    output logic                 busy,
    output logic                 settled
);

    localparam logic [CH_W:0] STEP_V = (CH_W+1)'(STEP);

    typedef enum logic {IDLE, SLEW} state_t;

    state_t         state_q, state, state_d;
    logic [W-1:0]   sel_word, target, latched, light_d;
    logic           sel_ok, differ, converge, settled_d;
    logic [CH_W:0]  ch_t, ch_l, ch_dist, ch_move, ch_upd;

    // Out-of-range sel matches no source and falls back to the latched target.
    always_comb begin
        sel_word = '0;
        sel_ok   = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_word = src[i*W +: W];
                sel_ok   = 1'b1;
            end
        end
        target = sel_ok ? sel_word : latched;
    end

    always_comb begin
        light_d = light;
        ch_t    = '0;
        ch_l    = '0;
        ch_dist = '0;
        ch_move = '0;
        ch_upd  = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_t    = {1'b0, target[c*CH_W +: CH_W]};
            ch_l    = {1'b0, light[c*CH_W +: CH_W]};
            ch_dist = (ch_t > ch_l) ? ch_t - ch_l : ch_l - ch_t;
            ch_move = (ch_dist < STEP_V) ? ch_dist : STEP_V;
            ch_upd  = (ch_t > ch_l) ? ch_l + ch_move : ch_l - ch_move;
            light_d[c*CH_W +: CH_W] = CH_W'(ch_upd);
        end
    end

    // The comparison drives the current state so busy tracks target changes between edges.
    always_comb begin
        differ   = (light != target);
        converge = (light_d == target);
        state    = state_q;
        unique case (state_q)
            IDLE: state = differ ? SLEW : IDLE;
            SLEW: state = differ ? SLEW : IDLE;
            default: state = IDLE;
        endcase
        settled_d = (state == SLEW) && enable && converge;
        state_d   = settled_d ? IDLE : state;
        busy      = (state == SLEW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            light   <= '0;
            latched <= '0;
            settled <= 1'b0;
        end else begin
            state_q <= state_d;
            settled <= settled_d;
            if (enable) light   <= light_d;
            if (sel_ok) latched <= sel_word;
        end
    end

endmodule

// File: tb/tb_light_slew_mux.sv
// Randomised and directed checks of light_slew_mux against an integer reference model.
// Two instances: defaults, and a 3-source, full-step variant for the illegal-select and one-edge cases.
module tb_light_slew_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [95:0] s0;
    logic [71:0] s1;
    logic [1:0]  sel0, sel1;
    logic [23:0] l0, l1;
    logic        busy0, busy1, set0, set1;

    int total = 0;
    int bad   = 0;

    logic [23:0] ml[2];
    logic [23:0] mlat[2];
    logic        ms[2];

    always #5 clk = ~clk;

    light_slew_mux dut (
        .clk(clk), .rst_n(rst_n), .src(s0), .sel(sel0), .enable(en),
        .light(l0), .busy(busy0), .settled(set0)
    );

    light_slew_mux #(.NUM_SRC(3), .STEP(256)) dut3 (
        .clk(clk), .rst_n(rst_n), .src(s1), .sel(sel1), .enable(en),
        .light(l1), .busy(busy1), .settled(set1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] word(input int d, input int k);
        logic [95:0] all;
        all = (d == 0) ? s0 : {24'h0, s1};
        return all[k*24 +: 24];
    endfunction

    function automatic int sel_of(input int d);
        return (d == 0) ? int'(sel0) : int'(sel1);
    endfunction

    function automatic logic [23:0] tgt(input int d);
        int n = (d == 0) ? 4 : 3;
        return (sel_of(d) < n) ? word(d, sel_of(d)) : mlat[d];
    endfunction

    function automatic logic [23:0] slew(input logic [23:0] l, input logic [23:0] t, input int step);
        logic [23:0] r;
        int a, b;
        for (int c = 0; c < 3; c++) begin
            a = int'(l[c*8 +: 8]);
            b = int'(t[c*8 +: 8]);
            if (a < b) a = a + (((b - a) < step) ? (b - a) : step);
            else       a = a - (((a - b) < step) ? (a - b) : step);
            r[c*8 +: 8] = 8'(a);
        end
        return r;
    endfunction

    task automatic check_all();
        check("light0",   64'(l0),    64'(ml[0]));
        check("settled0", 64'(set0),  64'(ms[0]));
        check("busy0",    64'(busy0), 64'(ml[0] != tgt(0)));
        check("light1",   64'(l1),    64'(ml[1]));
        check("settled1", 64'(set1),  64'(ms[1]));
        check("busy1",    64'(busy1), 64'(ml[1] != tgt(1)));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ml[d] = '0; mlat[d] = '0; ms[d] = 1'b0;
        end
    endtask

    task automatic tick();
        logic [23:0] nl[2], nlat[2];
        logic        ns[2];
        logic [23:0] t;
        for (int d = 0; d < 2; d++) begin
            t       = tgt(d);
            nl[d]   = en ? slew(ml[d], t, (d == 0) ? 16 : 256) : ml[d];
            ns[d]   = en && (ml[d] != t) && (nl[d] == t);
            nlat[d] = (sel_of(d) < ((d == 0) ? 4 : 3)) ? word(d, sel_of(d)) : mlat[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            ml[d] = nl[d]; ms[d] = ns[d]; mlat[d] = nlat[d];
        end
        check_all();
    endtask

    // Reset pulse placed between clock edges; checked before the next edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_light0", 64'(l0), 64'h0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic converge0(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            if (ml[0] == tgt(0)) break;
            tick();
        end
        check(tag, 64'(l0), 64'(tgt(0)));
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; en = 1'b0; s0 = '0; s1 = '0; sel0 = 2'd0; sel1 = 2'd0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Staggered channel arrival toward 0xFF8010
        en = 1'b1;
        s0[24 +: 24] = 24'hFF8010;
        tick();
        sel0 = 2'd1;
        pulses = 0;
        for (int e = 1; e <= 17; e++) begin
            tick();
            pulses += int'(set0);
            if (e == 1)  check("e1",  64'(l0), 64'h101010);
            if (e == 8)  check("e8",  64'(l0), 64'h808010);
            if (e == 15) check("e15", 64'(l0), 64'hF08010);
            if (e == 16) check("e16", 64'(l0), 64'hFF8010);
            if (e == 16) check("set16", 64'(set0), 64'h1);
        end
        check("pulses", 64'(pulses), 64'h1);

        // Single-edge R/B move with G already matching
        s0[72 +: 24] = 24'h808080;
        sel0 = 2'd3;
        converge0(20, "conv808080");
        tick();
        s0[48 +: 24] = 24'h7F8081;
        sel0 = 2'd2;
        tick();
        check("r29", 64'(l0), 64'h7F8081);
        check("s29", 64'(set0), 64'h1);
        tick();
        check("s29b", 64'(set0), 64'h0);

        // Climb to 0x404040, then retarget to zero
        s0[0 +: 24] = 24'h000000;
        sel0 = 2'd0;
        converge0(20, "conv0");
        tick();
        s0[24 +: 24] = 24'hFFFFFF;
        sel0 = 2'd1;
        for (int i = 0; i < 4; i++) tick();
        check("at40", 64'(l0), 64'h404040);
        sel0 = 2'd0;
        tick(); check("d30", 64'(l0), 64'h303030);
        tick(); check("d20", 64'(l0), 64'h202020);
        tick(); check("d10", 64'(l0), 64'h101010);
        tick(); check("d00", 64'(l0), 64'h000000);
        check("s31", 64'(set0), 64'h1);

        // Freeze mid-slew and resume
        sel0 = 2'd1;
        tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz", 64'(l0), 64'h202020);
            check("frzbusy", 64'(busy0), 64'h1);
        end
        en = 1'b1;
        tick();
        check("resume", 64'(l0), 64'h303030);

        // Async reset mid-slew, restart from zero
        async_reset();
        tick();
        check("restart", 64'(l0), 64'h101010);

        // Three-source variant: full step, then illegal select holds the latched target
        s1 = {24'hA5C3E1, 24'h123456, 24'h00FF00};
        sel1 = 2'd2;
        tick();
        check("full", 64'(l1), 64'hA5C3E1);
        check("fullset", 64'(set1), 64'h1);
        sel1 = 2'd3;
        tick();
        s1[48 +: 24] = 24'h0F0F0F;
        tick();
        check("ill", 64'(l1), 64'hA5C3E1);
        check("illbusy", 64'(busy1), 64'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) s0[$urandom_range(0, 3)*24 +: 24] = 24'($urandom);
            if ($urandom_range(0, 5) == 0) s1[$urandom_range(0, 2)*24 +: 24] = 24'($urandom);
            if ($urandom_range(0, 7) == 0) sel0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) sel1 = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) async_reset();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
